mod_exp_engine: RTL and testbench

Parametrised right-to-left binary modular exponentiation engine: computes c = m^e mod n for WIDTH-bit operands and EXP_WIDTH-bit exponents. It is the next generation of the RSA accelerator's exponentiation block and adds a start/done handshake, input validation, multiply-skip on zero exponent bits, and a selectable parallel or area-saving shared-multiplier mode. It sits between the RSA control/register interface and the modular multiplier datapath.

---
 rtl/mod_exp_pkg.sv | 20 ++
 rtl/interleaved_modmul.sv | 92 +++++++++
 rtl/mod_exp_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_mod_exp_engine.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_exp_pkg.sv
// Shared types and constants for the modular exponentiation engine.
// Contents:
//   state_t - engine FSM states (IDLE, CHECK, ISSUE, WAIT, FIN)
//   lat()   - multiplier latency in cycles, from start pulse to the
//             cycle on which its done pulse is consumed
package mod_exp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      ISSUE,
      WAIT,
      FIN
   } state_t;

   function automatic int lat(input int width);
      return width + 2;
   endfunction

endpackage

// File: rtl/interleaved_modmul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n.
// Scans a MSB-first; each step doubles the partial sum, adds b when the
// current bit of a is set, and then subtracts n up to twice.
// Requires a < n and b < n.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   start      - one-cycle pulse that captures a, b and n
//   a, b, n    - operands and modulus (WIDTH bits)
//   p          - result, held until the next start
//   done       - one-cycle pulse when p is valid
module interleaved_modmul
   import mod_exp_pkg::*;
#(
   parameter int WIDTH = 128
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH-1:0] p,
   output logic             done
);

   localparam int LAT = lat(WIDTH);
   localparam int CW  = $clog2(LAT) + 1;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] n_reg;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             running;

   logic [WIDTH-1:0] addend;
   logic [WIDTH+1:0] sum;
   logic [WIDTH+1:0] n_ext;
   logic [WIDTH+1:0] red1;
   logic [WIDTH+1:0] red2;
   logic [WIDTH-1:0] step_p;

   // The partial sum is below n, so 2*acc + b stays under 3n. Two extra
   // bits hold it without loss, and two conditional subtracts bring it
   // back below n.
   always_comb begin
      addend = a_reg[WIDTH-1] ? b_reg : {WIDTH{1'b0}};
      n_ext  = {2'b00, n_reg};
      sum    = {1'b0, acc, 1'b0} + {2'b00, addend};
      red1   = (sum >= n_ext) ? sum - n_ext : sum;
      red2   = (red1 >= n_ext) ? red1 - n_ext : red1;
      step_p = WIDTH'(red2);
   end

   // The counter starts at LAT-1. The first WIDTH counts perform the
   // WIDTH shift/add steps. The final count raises done, so the owner
   // sees done exactly LAT cycles after it sampled start.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg   <= '0;
         b_reg   <= '0;
         n_reg   <= '0;
         acc     <= '0;
         cnt     <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            n_reg   <= n;
            acc     <= '0;
            cnt     <= CW'(LAT - 1);
            running <= 1'b1;
         end else if (running) begin
            if (cnt == CW'(1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end else begin
               acc   <= step_p;
               a_reg <= a_reg << 1;
            end
            cnt <= cnt - CW'(1);
         end
      end
   end

   assign p = acc;

endmodule

// File: rtl/mod_exp_engine.sv
// Right-to-left binary modular exponentiation: c = m^e mod n.
// PARALLEL=1 runs the square and the multiply of each round on two
// multipliers at the same time. PARALLEL=0 shares one multiplier and
// spends one round per operation.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   start      - request; accepted only in IDLE
//   m, e, n    - base, exponent and modulus (m < n, n >= 2 expected)
//   busy       - high while a request is being processed
//   done       - one-cycle pulse when c and err are valid
//   c, err     - result and operand-violation flag, held until replaced
module mod_exp_engine
   import mod_exp_pkg::*;
#(
   parameter int WIDTH     = 128,
   parameter int EXP_WIDTH = 32,
   parameter int PARALLEL  = 1
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     m,
   input  logic [EXP_WIDTH-1:0] e,
   input  logic [WIDTH-1:0]     n,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     c,
   output logic                 err
);

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0]     base_reg;
   logic [WIDTH-1:0]     mod_reg;
   logic [WIDTH-1:0]     acc_reg;
   logic [EXP_WIDTH-1:0] exp_reg;
   logic                 issued_sq;
   logic                 issued_mul;
   logic                 sq_phase;

   logic                 issue_sq;
   logic                 issue_mul;
   logic                 round_done;
   logic                 shift;
   logic                 operand_bad;
   logic [EXP_WIDTH-1:0] exp_half;
   logic [EXP_WIDTH-1:0] exp_upd;
   logic [WIDTH-1:0]     acc_upd;

   logic [WIDTH-1:0]     sq_p;
   logic [WIDTH-1:0]     mul_p;
   logic                 sq_done;
   logic                 mul_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and round control.
   // The exponent shifts after a square. It also shifts after a multiply
   // when no square follows, which is always the case in parallel mode.
   // In shared mode, sq_phase records that the multiply of the current
   // bit is already done, so the next issue is its square.
   always_comb begin
      state_next  = state;
      issue_sq    = 1'b0;
      issue_mul   = 1'b0;
      exp_half    = exp_reg >> 1;
      operand_bad = (mod_reg < WIDTH'(2)) || (base_reg >= mod_reg);
      round_done  = (!issued_sq || sq_done) && (!issued_mul || mul_done);
      acc_upd     = issued_mul ? mul_p : acc_reg;
      shift       = issued_sq || (exp_half == '0);
      exp_upd     = shift ? exp_half : exp_reg;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = CHECK;
            end
         end
         CHECK: begin
            if (operand_bad || (exp_reg == '0)) begin
               state_next = FIN;
            end else begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (PARALLEL != 0) begin
               issue_sq  = (exp_half != '0);
               issue_mul = exp_reg[0];
            end else begin
               issue_mul = exp_reg[0] && !sq_phase;
               issue_sq  = !issue_mul;
            end
            state_next = WAIT;
         end
         WAIT: begin
            if (round_done) begin
               state_next = (exp_upd != '0) ? ISSUE : FIN;
            end
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath and output registers.
   // busy and done trail the state by one cycle, so busy rises the cycle
   // after accept, and done pulses as busy falls.
   // c and err change only on a CHECK short-cut or the final round.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         c          <= '0;
         err        <= 1'b0;
         base_reg   <= '0;
         mod_reg    <= '0;
         acc_reg    <= '0;
         exp_reg    <= '0;
         issued_sq  <= 1'b0;
         issued_mul <= 1'b0;
         sq_phase   <= 1'b0;
      end else begin
         busy <= (state == CHECK) || (state == ISSUE) || (state == WAIT);
         done <= (state == FIN);
         case (state)
            IDLE: begin
               if (start) begin
                  base_reg <= m;
                  exp_reg  <= e;
                  mod_reg  <= n;
               end
            end
            CHECK: begin
               acc_reg  <= WIDTH'(1);
               sq_phase <= 1'b0;
               if (operand_bad) begin
                  c   <= '0;
                  err <= 1'b1;
               end else if (exp_reg == '0) begin
                  c   <= WIDTH'(1);
                  err <= 1'b0;
               end
            end
            ISSUE: begin
               issued_sq  <= issue_sq;
               issued_mul <= issue_mul;
            end
            WAIT: begin
               if (round_done) begin
                  acc_reg  <= acc_upd;
                  exp_reg  <= exp_upd;
                  sq_phase <= issued_mul && !shift;
                  if (issued_sq) begin
                     base_reg <= sq_p;
                  end
                  if (exp_upd == '0) begin
                     c   <= acc_upd;
                     err <= 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Multiplier arrangement. In parallel mode the square and the multiply
   // each get a dedicated unit. In shared mode one unit serves both, and
   // its outputs fan out to the square and multiply paths.
   generate
      if (PARALLEL != 0) begin : g_parallel
         interleaved_modmul #(.WIDTH(WIDTH)) u_sq (
            .clk   (clk),
            .reset (reset),
            .start (issue_sq),
            .a     (base_reg),
            .b     (base_reg),
            .n     (mod_reg),
            .p     (sq_p),
            .done  (sq_done)
         );
         interleaved_modmul #(.WIDTH(WIDTH)) u_mul (
            .clk   (clk),
            .reset (reset),
            .start (issue_mul),
            .a     (acc_reg),
            .b     (base_reg),
            .n     (mod_reg),
            .p     (mul_p),
            .done  (mul_done)
         );
      end else begin : g_shared
         logic [WIDTH-1:0] shared_p;
         logic             shared_done;
         interleaved_modmul #(.WIDTH(WIDTH)) u_shared (
            .clk   (clk),
            .reset (reset),
            .start (issue_sq | issue_mul),
            .a     (issue_mul ? acc_reg : base_reg),
            .b     (base_reg),
            .n     (mod_reg),
            .p     (shared_p),
            .done  (shared_done)
         );
         assign sq_p     = shared_p;
         assign mul_p    = shared_p;
         assign sq_done  = shared_done;
         assign mul_done = shared_done;
      end
   endgenerate

endmodule

// File: tb/tb_mod_exp_engine.sv
// Testbench for mod_exp_engine. Four engines run side by side: 16-bit and
// 128-bit operands, each in parallel and shared-multiplier form. Each
// 16-bit request runs on both 16-bit engines at once; each 128-bit
// request runs on both 128-bit engines at once.
module tb_mod_exp_engine;

   typedef struct {
      logic [127:0] m;
      logic [31:0]  e;
      logic [127:0] n;
      logic [127:0] c;
      bit           err;
      int           cyc1;
      int           cyc0;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         start16;
   logic         start128;
   logic [15:0]  m16, e16, n16;
   logic [127:0] m128, n128;
   logic [31:0]  e128;

   logic         busy16P1, done16P1, err16P1, busy16P0, done16P0, err16P0;
   logic [15:0]  c16P1, c16P0;
   logic         busy128P1, done128P1, err128P1, busy128P0, done128P0, err128P0;
   logic [127:0] c128P1, c128P0;

   int           checks = 0;
   int           errors = 0;

   logic [127:0] resC[2];
   logic         resErr[2];
   int           resCyc[2];
   int           resCnt[2];
   logic         resBusy1[2];
   logic         resBusyDone[2];

   vec_t         vecs[12];

   always #5 clk = ~clk;

   mod_exp_engine #(.WIDTH(16), .EXP_WIDTH(16), .PARALLEL(1)) dut16P1 (
      .clk(clk), .reset(reset), .start(start16), .m(m16), .e(e16), .n(n16),
      .busy(busy16P1), .done(done16P1), .c(c16P1), .err(err16P1));
   mod_exp_engine #(.WIDTH(16), .EXP_WIDTH(16), .PARALLEL(0)) dut16P0 (
      .clk(clk), .reset(reset), .start(start16), .m(m16), .e(e16), .n(n16),
      .busy(busy16P0), .done(done16P0), .c(c16P0), .err(err16P0));
   mod_exp_engine #(.WIDTH(128), .EXP_WIDTH(32), .PARALLEL(1)) dut128P1 (
      .clk(clk), .reset(reset), .start(start128), .m(m128), .e(e128), .n(n128),
      .busy(busy128P1), .done(done128P1), .c(c128P1), .err(err128P1));
   mod_exp_engine #(.WIDTH(128), .EXP_WIDTH(32), .PARALLEL(0)) dut128P0 (
      .clk(clk), .reset(reset), .start(start128), .m(m128), .e(e128), .n(n128),
      .busy(busy128P0), .done(done128P0), .c(c128P0), .err(err128P0));

   // Reference: left-to-right square-and-multiply on wide integers
   function automatic logic [127:0] refModExp(input logic [127:0] mv, input logic [31:0] ev,
                                              input logic [127:0] nv);
      logic [255:0] r;
      logic [255:0] nw;
      logic [255:0] mw;
      if (nv < 2 || mv >= nv) return '0;
      nw = {128'd0, nv};
      mw = {128'd0, mv};
      r  = 256'd1;
      for (int i = 31; i >= 0; i--) begin
         r = (r * r) % nw;
         if (ev[i]) r = (r * mw) % nw;
      end
      return r[127:0];
   endfunction

   function automatic int bitLen(input logic [31:0] v);
      int r = 0;
      for (int i = 0; i < 32; i++) if (v[i]) r = i + 1;
      return r;
   endfunction

   function automatic int popCount(input logic [31:0] v);
      int r = 0;
      for (int i = 0; i < 32; i++) if (v[i]) r++;
      return r;
   endfunction

   // Expected done cycle (accept edge = cycle 0)
   function automatic int expCycles(input int w, input int par, input logic [31:0] ev, input bit bad);
      int k;
      if (bad || ev == 0) k = 0;
      else if (par != 0)  k = bitLen(ev);
      else                k = popCount(ev) + bitLen(ev) - 1;
      return 2 + k * (w + 3);
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   // Issues one request on the chosen engine pair. It records each
   // engine's result and done cycle, and how many done pulses were seen.
   // A non-zero inject pokes a second start at that cycle while busy.
   task automatic applyStimulus(input bit wide, input logic [127:0] mv, input logic [31:0] ev,
                                input logic [127:0] nv, input int inject);
      int     cyc;
      logic   d[2];
      logic   b[2];
      for (int i = 0; i < 2; i++) begin
         resC[i] = '0; resErr[i] = 1'bx; resCyc[i] = -1; resCnt[i] = 0;
         resBusy1[i] = 1'b0; resBusyDone[i] = 1'b1;
      end
      @(negedge clk);
      if (wide) begin
         m128 = mv; e128 = ev; n128 = nv; start128 = 1'b1;
      end else begin
         m16 = mv[15:0]; e16 = ev[15:0]; n16 = nv[15:0]; start16 = 1'b1;
      end
      @(posedge clk);
      #1;
      start16 = 1'b0; start128 = 1'b0;
      cyc = 0;
      while ((resCyc[0] < 0 || resCyc[1] < 0 || cyc < 8 + ((resCyc[0] > resCyc[1]) ? resCyc[0] : resCyc[1]))
             && cyc < 10000) begin
         @(posedge clk);
         cyc++;
         #1;
         start16 = 1'b0; start128 = 1'b0;
         d[0] = wide ? done128P1 : done16P1;
         d[1] = wide ? done128P0 : done16P0;
         b[0] = wide ? busy128P1 : busy16P1;
         b[1] = wide ? busy128P0 : busy16P0;
         for (int i = 0; i < 2; i++) begin
            if (cyc == 1) resBusy1[i] = b[i];
            if (d[i] === 1'b1) begin
               resCnt[i]++;
               if (resCyc[i] < 0) begin
                  resCyc[i] = cyc;
                  resBusyDone[i] = b[i];
                  if (i == 0) begin
                     resC[0]   = wide ? c128P1 : {112'd0, c16P1};
                     resErr[0] = wide ? err128P1 : err16P1;
                  end else begin
                     resC[1]   = wide ? c128P0 : {112'd0, c16P0};
                     resErr[1] = wide ? err128P0 : err16P0;
                  end
               end
            end
         end
         if (inject > 0 && cyc == inject) begin
            m16 = 16'd9; e16 = 16'd3; n16 = 16'd7; start16 = 1'b1;
         end
      end
   endtask

   task automatic checkResults(input string tag, input logic [127:0] wc, input bit we,
                               input int wc1, input int wc0);
      for (int i = 0; i < 2; i++) begin
         string ln;
         ln = (i == 0) ? "P1" : "P0";
         checkOutput($sformatf("%s %s c", tag, ln), resC[i], wc);
         checkOutput($sformatf("%s %s err", tag, ln), {127'd0, resErr[i]}, {127'd0, we});
         checkOutput($sformatf("%s %s done cycle", tag, ln), resCyc[i], (i == 0) ? wc1 : wc0);
         checkOutput($sformatf("%s %s done pulses", tag, ln), resCnt[i], 1);
         checkOutput($sformatf("%s %s busy at cycle 1", tag, ln), {127'd0, resBusy1[i]}, 128'd1);
         checkOutput($sformatf("%s %s busy at done", tag, ln), {127'd0, resBusyDone[i]}, 128'd0);
      end
   endtask

   initial begin
      logic [127:0] mv, nv, wc;
      logic [31:0]  ev;
      bit           bad;
      int           n1, n0;

      vecs[0]  = '{128'd4,     32'd13,    128'd497,   128'd445,   1'b0, 78,  116};
      vecs[1]  = '{128'd5,     32'd0,     128'd7,     128'd1,     1'b0, 2,   2};
      vecs[2]  = '{128'd0,     32'd5,     128'd7,     128'd0,     1'b0, 59,  78};
      vecs[3]  = '{128'd0,     32'd3,     128'd1,     128'd0,     1'b1, 2,   2};
      vecs[4]  = '{128'd9,     32'd3,     128'd7,     128'd0,     1'b1, 2,   2};
      vecs[5]  = '{128'd3,     32'd5,     128'd7,     128'd5,     1'b0, 59,  78};
      vecs[6]  = '{128'd6,     32'd1,     128'd7,     128'd6,     1'b0, 21,  21};
      vecs[7]  = '{128'd2,     32'd16,    128'd65521, 128'd15,    1'b0, 97,  97};
      vecs[8]  = '{128'd65534, 32'd65535, 128'd65535, 128'd65534, 1'b0, 306, 591};
      vecs[9]  = '{128'd7,     32'd2,     128'd7,     128'd0,     1'b1, 2,   2};
      vecs[10] = '{128'd1,     32'd3,     128'd2,     128'd1,     1'b0, 40,  59};
      vecs[11] = '{128'd2,     32'd4,     128'd11,    128'd5,     1'b0, 59,  59};

      reset = 1'b1; start16 = 1'b0; start128 = 1'b0;
      m16 = '0; e16 = '0; n16 = '0; m128 = '0; e128 = '0; n128 = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("reset busy16P1", {127'd0, busy16P1}, 128'd0);
      checkOutput("reset done16P0", {127'd0, done16P0}, 128'd0);
      checkOutput("reset c16P1", {112'd0, c16P1}, 128'd0);
      checkOutput("reset err16P0", {127'd0, err16P0}, 128'd0);
      checkOutput("reset busy128P0", {127'd0, busy128P0}, 128'd0);
      checkOutput("reset c128P1", c128P1, 128'd0);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, vecs[i].m, vecs[i].e, vecs[i].n, 0);
         checkResults($sformatf("vec%0d", i), vecs[i].c, vecs[i].err, vecs[i].cyc1, vecs[i].cyc0);
      end

      // A start while busy, carrying different operands, must be ignored
      applyStimulus(1'b0, 128'd4, 32'd13, 128'd497, 5);
      checkResults("start-while-busy", 128'd445, 1'b0, 78, 116);

      // Reset pulled while both 16-bit engines wait on their multipliers
      @(negedge clk);
      m16 = 16'd4; e16 = 16'd13; n16 = 16'd497; start16 = 1'b1;
      @(posedge clk);
      #1;
      start16 = 1'b0;
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      checkOutput("pre-reset busy P1", {127'd0, busy16P1}, 128'd1);
      checkOutput("pre-reset c P0", {112'd0, c16P0}, 128'd445);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("mid-reset busy P1", {127'd0, busy16P1}, 128'd0);
      checkOutput("mid-reset busy P0", {127'd0, busy16P0}, 128'd0);
      checkOutput("mid-reset c P1", {112'd0, c16P1}, 128'd0);
      checkOutput("mid-reset c P0", {112'd0, c16P0}, 128'd0);
      checkOutput("mid-reset err P1", {127'd0, err16P1}, 128'd0);
      n1 = 0; n0 = 0;
      for (int i = 0; i < 150; i++) begin
         @(posedge clk);
         #1;
         if (done16P1 === 1'b1) n1++;
         if (done16P0 === 1'b1) n0++;
      end
      checkOutput("post-reset done pulses P1", n1, 0);
      checkOutput("post-reset done pulses P0", n0, 0);
      applyStimulus(1'b0, 128'd4, 32'd13, 128'd497, 0);
      checkResults("after-reset", 128'd445, 1'b0, 78, 116);

      // Random 16-bit requests, some with m >= n
      for (int i = 0; i < 8; i++) begin
         nv = 128'($urandom_range(65535, 2));
         mv = (i % 4 == 3) ? 128'($urandom_range(65535, 0)) : 128'($urandom) % nv;
         ev = 32'($urandom_range(65535, 0));
         bad = (nv < 2) || (mv >= nv);
         wc = refModExp(mv, ev, nv);
         applyStimulus(1'b0, mv, ev, nv, 0);
         checkResults($sformatf("rand16_%0d", i), (!bad && ev == 0) ? 128'd1 : wc, bad,
                      expCycles(16, 1, ev, bad), expCycles(16, 0, ev, bad));
      end

      // Random 128-bit requests: the e=65537 public exponent, then random e
      for (int i = 0; i < 3; i++) begin
         nv = {$urandom, $urandom, $urandom, $urandom};
         if (nv < 2) nv = 128'd3;
         mv = {$urandom, $urandom, $urandom, $urandom} % nv;
         ev = (i == 0) ? 32'd65537 : $urandom;
         bad = 1'b0;
         wc = refModExp(mv, ev, nv);
         applyStimulus(1'b1, mv, ev, nv, 0);
         checkResults($sformatf("rand128_%0d", i), (ev == 0) ? 128'd1 : wc, 1'b0,
                      expCycles(128, 1, ev, bad), expCycles(128, 0, ev, bad));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
